// File: rtl/timing_nco_pkg.sv
// timing_nco_pkg: widths, step limits and mu scaling shared by the timing-recovery NCO.
package timing_pkg;
   localparam int NB_CTRL    = 23;
   localparam int NBF_CTRL   = 18;
   localparam int NB_ACC     = 24;
   localparam int NB_MU      = 16;
   localparam int CTRL_SHIFT = NB_ACC - NBF_CTRL;
   localparam int NB_WRAW    = NB_CTRL + 8;
   localparam logic [NB_ACC-1:0] W_NOM = 24'h800000;
   localparam logic [NB_ACC-1:0] W_MIN = 24'h400000;
   localparam logic [NB_ACC-1:0] W_MAX = 24'hC00000;
   // mu = eta / W_NOM = 2*eta, saturating just below 1.0
   function automatic logic [NB_MU-1:0] eta_to_mu(input logic [NB_ACC-1:0] eta);
      return eta[NB_ACC-1] ? '1 : eta[NB_ACC-2 -: NB_MU];
   endfunction
endpackage

// File: rtl/timing_nco_if.sv
// timing_nco_if: sample/control inputs and strobe/mu/debug outputs of the timing NCO.
interface timing_nco_if;
   import timing_pkg::*;
   logic               i_sample_en;
   logic [NB_CTRL-1:0] i_ctrl;
   logic               i_ctrl_valid;
   logic               o_strobe;
   logic [NB_MU-1:0]   o_mu;
   logic [NB_ACC-1:0]  o_w;
   logic               o_sat;
   modport master (output i_sample_en, i_ctrl, i_ctrl_valid, input o_strobe, o_mu, o_w, o_sat);
   modport slave  (input i_sample_en, i_ctrl, i_ctrl_valid, output o_strobe, o_mu, o_w, o_sat);
endinterface

// File: rtl/timing_nco_step_calc.sv
// nco_step_calc: maps the loop-filter word onto a clamped NCO step W around W_NOM.
module nco_step_calc
   import timing_pkg::*;
(
   input  logic [NB_CTRL-1:0] ctrl_i,
   output logic [NB_ACC-1:0]  w_o,
   output logic               sat_o
);
   localparam logic signed [NB_WRAW-1:0] W_NOM_X = NB_WRAW'(W_NOM);
   localparam logic signed [NB_WRAW-1:0] W_MIN_X = NB_WRAW'(W_MIN);
   localparam logic signed [NB_WRAW-1:0] W_MAX_X = NB_WRAW'(W_MAX);
   logic signed [NB_WRAW-1:0] v_aligned, w_raw;
   logic lo, hi;
   assign v_aligned = $signed({{(NB_WRAW-NB_CTRL){ctrl_i[NB_CTRL-1]}}, ctrl_i}) <<< CTRL_SHIFT;
   assign w_raw     = W_NOM_X + v_aligned;
   always_comb begin
      lo    = w_raw < W_MIN_X;
      hi    = w_raw > W_MAX_X;
      w_o   = lo ? W_MIN : hi ? W_MAX : w_raw[NB_ACC-1:0];
      sat_o = lo | hi;
   end
endmodule

// File: rtl/timing_nco.sv
// timing_nco: modulo-1 decrementing phase accumulator emitting interpolation strobes with mu.
module timing_nco
   import timing_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   timing_nco_if.slave bus
);
   logic [NB_CTRL-1:0] ctrl_q, ctrl_d;
   logic [NB_ACC-1:0]  w_q, w_d, eta_q, eta_d;
   logic [NB_MU-1:0]   mu_q, mu_d;
   logic               sat_q, sat_d, strobe_q, strobe_d;
   logic [NB_ACC:0]    diff;
   nco_step_calc u_step (
      .ctrl_i (ctrl_q),
      .w_o    (w_d),
      .sat_o  (sat_d)
   );
   // a sample decides against the step registered before it, so a coincident ctrl update lands later
   always_comb begin
      ctrl_d   = bus.i_ctrl_valid ? bus.i_ctrl : ctrl_q;
      diff     = {1'b0, eta_q} - {1'b0, w_q};
      eta_d    = bus.i_sample_en ? diff[NB_ACC-1:0] : eta_q;
      strobe_d = bus.i_sample_en & diff[NB_ACC];
      mu_d     = strobe_d ? eta_to_mu(eta_q) : mu_q;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctrl_q   <= '0;
         w_q      <= W_NOM;
         sat_q    <= 1'b0;
         eta_q    <= '0;
         strobe_q <= 1'b0;
         mu_q     <= '0;
      end else begin
         ctrl_q   <= ctrl_d;
         w_q      <= w_d;
         sat_q    <= sat_d;
         eta_q    <= eta_d;
         strobe_q <= strobe_d;
         mu_q     <= mu_d;
      end
   end
   assign bus.o_strobe = strobe_q;
   assign bus.o_mu     = mu_q;
   assign bus.o_w      = w_q;
   assign bus.o_sat    = sat_q;
endmodule

// File: doc/timing_nco.md
# timing_nco

Timing-recovery NCO that closes the symbol-synchronisation loop downstream of the PI loop filter. It consumes the filter's registered control word and enable, and runs a modulo-1 decrementing phase accumulator once per input sample, nominally at 2 samples/symbol. It emits an interpolation strobe with fractional interval mu to the interpolator and timing error detector (TED), closing the loop.

## Interface
- NB_CTRL, 23, control word width, signed S(23,18)
- NBF_CTRL, 18, control word fractional bits
- NB_ACC, 24, phase accumulator width, unsigned U(24,24), range [0,1)
- NB_MU, 16, mu output width, unsigned U(16,16)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_sample_en  in  1  one-cycle pulse per input sample; advances the NCO
- i_ctrl  in  NB_CTRL  loop-filter output v, S(23,18)
- i_ctrl_valid  in  1  loop-filter output enable; i_ctrl is sampled only when this is high
- o_strobe  out  1  one-cycle pulse: interpolate this sample
- o_mu  out  NB_MU  fractional interval for the strobed sample, held between strobes
- o_w  out  NB_ACC  current step W after clamping, U(24,24), for debug
- o_sat  out  1  high while W is clamped

## Operation
- Constants: W_NOM = 0.5 (24'h800000), W_MIN = 0.25 (24'h400000), W_MAX = 0.75 (24'hC00000).
- Control register ctrl_r updates to i_ctrl on i_ctrl_valid. Otherwise it holds.
- Step computation:
  - v_aligned = sign-extend(ctrl_r) << (NB_ACC − NBF_CTRL), giving 6 bits of shift.
  - w_raw = W_NOM + v_aligned, computed in NB_CTRL+8 signed bits.
  - W = clamp(w_raw, W_MIN, W_MAX). o_sat = 1 when clamping is active.
  - W is registered as w_r, one cycle after ctrl_r.
- On i_sample_en:
  - diff = eta − w_r, computed in NB_ACC+1 signed bits.
  - Underflow when diff < 0:
    - o_strobe = 1.
    - mu = eta × (1/W_NOM) = eta << 1. Take the top NB_MU bits, saturating to 16'hFFFF if the result is ≥ 1.0.
  - eta_next = diff mod 1, i.e. the low NB_ACC bits.
- No i_sample_en: eta, o_mu and o_strobe = 0 all hold.
- Simultaneous i_ctrl_valid and i_sample_en: that sample uses the old w_r. The new control word first affects the sample_en at least 2 cycles later.
- diff == 0 is not an underflow.

## Timing
- Reset values: eta = 0, ctrl_r = 0, w_r = W_NOM, o_strobe = 0, o_mu = 0, o_w = 24'h800000, o_sat = 0.
- o_strobe and o_mu are registered. They appear 1 cycle after the i_sample_en cycle. o_strobe is high for exactly 1 cycle.
- Back-to-back i_sample_en, one per cycle, is supported. Each pulse yields an independent strobe decision.
- ctrl-to-W latency is 2 cycles: i_ctrl_valid → ctrl_r → w_r / o_w / o_sat.
- Reset mid-operation: all state returns to reset values on the next edge, and any pending strobe is dropped.
- First i_sample_en after reset: eta = 0 → underflow, strobe with mu = 0, eta becomes 0.5 (with ctrl 0).

## Structure
- Package timing_pkg holds:
  - NB_ACC, NB_MU
  - W_NOM, W_MIN, W_MAX
  - the ACC/CTRL alignment shift constant (NB_ACC − NBF_CTRL)
- Sub-module nco_step_calc is combinational: ctrl_r → clamped W, sat flag.
- Top-level timing_nco holds:
  - ctrl_r, w_r, eta
  - the underflow/mu logic
  - the output registers

## Test plan
- Reset, ctrl 0, continuous i_sample_en → strobes on samples 1, 3, 5…, always with o_mu = 0. o_w = 24'h800000, o_sat = 0.
- i_ctrl = 23'h010000 (+0.25) then samples → o_w = 24'hC00000. Over 4 samples: strobe, strobe, strobe, none. mu = 16'h0000, 16'h8000, 16'hFFFF (saturated). eta returns to 0.
- i_ctrl = 23'h040000 (+1.0) → o_w = 24'hC00000 and o_sat = 1. Then i_ctrl = 23'h7C0000 (−1.0) → o_w = 24'h400000, o_sat = 1, one strobe every 4 samples.
- i_ctrl_valid coincident with i_sample_en → that sample's strobe decision uses the previous W. Check against a reference model.
- rst_n asserted between a strobing i_sample_en and its output cycle → no strobe is emitted, and all outputs return to reset values.
- Random ctrl in ±0.3, random sample_en density → compare strobe/mu stream with a bit-exact golden model over 10k samples.
